// File: rtl/uart_debugger_pkg.sv
// Shared types and constants for the UART debug port: dump FSM and RX state
// encodings, command byte, trailer bytes and frame length.
package uart_debugger_pkg;

  typedef enum logic [4:0] {
    ST_IDLE    = 5'd0,
    ST_LATCH   = 5'd1,
    ST_SEND    = 5'd2,
    ST_WAIT    = 5'd3,
    ST_ADVANCE = 5'd4,
    ST_CLOSE   = 5'd5
  } state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  localparam logic [7:0] CMD_DUMP = 8'h4C;
  localparam logic [7:0] CR_BYTE  = 8'h0D;
  localparam logic [7:0] LF_BYTE  = 8'h0A;

  // Start bit + 8 data bits + stop bit.
  localparam int UART_FRAME_BITS = 10;

endpackage

// File: rtl/uart_debugger_tx.sv
// 8N1 byte transmitter for the debug port: one byte per start pulse, done_o
// strobes in the last cycle of the stop bit.
module debug_uart_tx
  import uart_debugger_pkg::*;
#(
  parameter int DIVIDER_TICKS = 1023
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       start_i,
  input  logic [7:0] data_i,
  output logic       tx_o,
  output logic       busy_o,
  output logic       done_o
);

  localparam int TICK_W = $clog2(DIVIDER_TICKS);
  localparam logic [TICK_W-1:0] FULL_TICK = TICK_W'(DIVIDER_TICKS - 1);
  localparam logic [3:0] LAST_BIT = 4'(UART_FRAME_BITS - 1);

  logic              tx_q;
  logic              busy_q;
  logic [TICK_W-1:0] tick_q;
  logic [3:0]        bit_q;
  logic [8:0]        shift_q;

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else if (!busy_q) begin
      if (start_i) begin
        busy_q  <= 1'b1;
        tx_q    <= 1'b0;
        shift_q <= {1'b1, data_i};
        tick_q  <= '0;
        bit_q   <= '0;
      end
    end else if (tick_q == FULL_TICK) begin
      tick_q <= '0;
      if (bit_q == LAST_BIT) begin
        busy_q <= 1'b0;
        tx_q   <= 1'b1;
      end else begin
        bit_q   <= bit_q + 4'd1;
        tx_q    <= shift_q[0];
        shift_q <= {1'b0, shift_q[8:1]};
      end
    end else begin
      tick_q <= tick_q + TICK_W'(1);
    end
  end

  assign tx_o   = tx_q;
  assign busy_o = busy_q;
  assign done_o = busy_q && (bit_q == LAST_BIT) && (tick_q == FULL_TICK);

endmodule

// File: rtl/uart_debugger.sv
// UART debug port: receives 8N1 commands and, on 'L', dumps a snapshot of
// data_in MSB byte first. Define UART_DEBUGGER_CRLF_EN to append CR LF.
module uart_debugger
  import uart_debugger_pkg::*;
#(
  parameter int DIVIDER_TICKS = 1023,
  parameter int DATA_WIDTH    = 24
) (
  input  logic                  clk_in,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  debug_uart_rx_in,
  output logic                  tx_out,
  output logic                  debug_start,
  output logic [4:0]            currentState,
  output logic                  tx_start,
  output logic [4:0]            current_position,
  output logic [7:0]            debug_command,
  output logic                  debug_command_pulse,
  output logic                  debug_command_busy,
  output logic                  do_close
);

  localparam int NBYTES = DATA_WIDTH / 8;
`ifdef UART_DEBUGGER_CRLF_EN
  localparam logic [4:0] LAST_POS = 5'(NBYTES + 1);
`else
  localparam logic [4:0] LAST_POS = 5'(NBYTES - 1);
`endif
  localparam int TICK_W = $clog2(DIVIDER_TICKS);
  localparam logic [TICK_W-1:0] HALF_TICK = TICK_W'(DIVIDER_TICKS / 2 - 1);
  localparam logic [TICK_W-1:0] FULL_TICK = TICK_W'(DIVIDER_TICKS - 1);

  // ---------------- command receiver ----------------
  logic              rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_e         rx_state_q;
  logic [TICK_W-1:0] rx_cnt_q;
  logic [2:0]        rx_bit_q;
  logic [7:0]        rx_shift_q;
  logic [7:0]        cmd_q;
  logic              cmd_pulse_q;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      rx_prev_q   <= 1'b1;
      rx_state_q  <= RX_IDLE;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      rx_shift_q  <= '0;
      cmd_q       <= '0;
      cmd_pulse_q <= 1'b0;
    end else begin
      rx_meta_q   <= debug_uart_rx_in;
      rx_sync_q   <= rx_meta_q;
      rx_prev_q   <= rx_sync_q;
      cmd_pulse_q <= 1'b0;
      case (rx_state_q)
        RX_IDLE: begin
          if (rx_prev_q && !rx_sync_q) begin
            rx_state_q <= RX_START;
            rx_cnt_q   <= '0;
          end
        end
        RX_START: begin
          if (rx_cnt_q == HALF_TICK) begin
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            // A start bit that is high again at mid-bit was a glitch.
            rx_state_q <= rx_sync_q ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt_q <= rx_cnt_q + TICK_W'(1);
          end
        end
        RX_DATA: begin
          if (rx_cnt_q == FULL_TICK) begin
            rx_cnt_q   <= '0;
            rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
            if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
            else                  rx_bit_q   <= rx_bit_q + 3'd1;
          end else begin
            rx_cnt_q <= rx_cnt_q + TICK_W'(1);
          end
        end
        RX_STOP: begin
          if (rx_cnt_q == FULL_TICK) begin
            rx_cnt_q   <= '0;
            rx_state_q <= RX_IDLE;
            if (rx_sync_q) begin
              cmd_q       <= rx_shift_q;
              cmd_pulse_q <= 1'b1;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + TICK_W'(1);
          end
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  // ---------------- dump sequencer ----------------
  state_e                state_q, state_d;
  logic [4:0]            pos_q, pos_d;
  logic [DATA_WIDTH-1:0] snap_q;
  logic [7:0]            tx_byte;
  logic                  tx_busy, tx_done;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pos_q   <= '0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
    end
  end

  // NOTE: snapshot is pure datapath, only read after LATCH writes it, so it needs no reset.
  always_ff @(posedge clk_in) begin
    if (state_q == ST_LATCH) snap_q <= data_in;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d            = state_q;
    pos_d              = pos_q;
    debug_start        = 1'b0;
    tx_start           = 1'b0;
    do_close           = 1'b0;
    debug_command_busy = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_pulse_q && cmd_q == CMD_DUMP) state_d = ST_LATCH;
      end
      ST_LATCH: begin
        debug_start        = 1'b1;
        debug_command_busy = 1'b1;
        pos_d              = '0;
        state_d            = ST_SEND;
      end
      ST_SEND: begin
        debug_command_busy = 1'b1;
        if (!tx_busy) begin
          tx_start = 1'b1;
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        debug_command_busy = 1'b1;
        if (tx_done) state_d = ST_ADVANCE;
      end
      ST_ADVANCE: begin
        debug_command_busy = 1'b1;
        if (pos_q == LAST_POS) begin
          state_d = ST_CLOSE;
        end else begin
          pos_d   = pos_q + 5'd1;
          state_d = ST_SEND;
        end
      end
      ST_CLOSE: begin
        do_close = 1'b1;
        pos_d    = '0;
        state_d  = ST_IDLE;
      end
      default: begin
        pos_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Position 0 is the most significant byte of the snapshot.
  always_comb begin
    tx_byte = '0;
    for (int i = 0; i < NBYTES; i++) begin
      if (pos_q == 5'(i)) tx_byte = snap_q[DATA_WIDTH-1-8*i -: 8];
    end
`ifdef UART_DEBUGGER_CRLF_EN
    if (pos_q == 5'(NBYTES))     tx_byte = CR_BYTE;
    if (pos_q == 5'(NBYTES + 1)) tx_byte = LF_BYTE;
`endif
  end

  debug_uart_tx #(
    .DIVIDER_TICKS(DIVIDER_TICKS)
  ) u_tx (
    .clk_in (clk_in),
    .reset  (reset),
    .start_i(tx_start),
    .data_i (tx_byte),
    .tx_o   (tx_out),
    .busy_o (tx_busy),
    .done_o (tx_done)
  );

  assign currentState        = state_q;
  assign current_position    = pos_q;
  assign debug_command       = cmd_q;
  assign debug_command_pulse = cmd_pulse_q;

endmodule

// File: tb/tb_uart_debugger.sv
// Self-checking bench for uart_debugger: table of RX command vectors with
// expected strobes/dumps, plus hand-written busy-time and reset corner cases.
module tb_uart_debugger;

  localparam int D  = 16;
  localparam int W  = 24;
  localparam int NB = W / 8;
`ifdef UART_DEBUGGER_CRLF_EN
  localparam int NB_EXP = NB + 2;
`else
  localparam int NB_EXP = NB;
`endif

  logic         clk   = 1'b0;
  logic         reset = 1'b1;
  logic         rx    = 1'b1;
  logic [W-1:0] data_in = '0;
  logic         tx_out, debug_start, tx_start, debug_command_pulse;
  logic         debug_command_busy, do_close;
  logic [4:0]   currentState, current_position;
  logic [7:0]   debug_command;

  always #5 clk = ~clk;

  uart_debugger #(
    .DIVIDER_TICKS(D),
    .DATA_WIDTH   (W)
  ) dut (
    .clk_in             (clk),
    .reset              (reset),
    .data_in            (data_in),
    .debug_uart_rx_in   (rx),
    .tx_out             (tx_out),
    .debug_start        (debug_start),
    .currentState       (currentState),
    .tx_start           (tx_start),
    .current_position   (current_position),
    .debug_command      (debug_command),
    .debug_command_pulse(debug_command_pulse),
    .debug_command_busy (debug_command_busy),
    .do_close           (do_close)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Strobe counters and TX-start position log, sampled on the falling edge.
  int n_pulse = 0, n_start = 0, n_close = 0, n_txs = 0, n_stop_err = 0;
  logic [4:0] pos_log[$];
  logic [7:0] got_bytes[$];

  always @(negedge clk) begin
    if (debug_command_pulse) n_pulse <= n_pulse + 1;
    if (debug_start)         n_start <= n_start + 1;
    if (do_close)            n_close <= n_close + 1;
    if (tx_start) begin
      n_txs <= n_txs + 1;
      pos_log.push_back(current_position);
    end
  end

  // Independent 8N1 decoder on tx_out, sampling mid-bit.
  int         mon_cnt  = 0;
  logic       mon_busy = 1'b0;
  logic [7:0] mon_sh   = '0;

  always @(negedge clk) begin
    if (reset) begin
      mon_busy <= 1'b0;
    end else if (!mon_busy) begin
      if (tx_out == 1'b0) begin
        mon_busy <= 1'b1;
        mon_cnt  <= 1;
      end
    end else begin
      mon_cnt <= mon_cnt + 1;
      if (mon_cnt == 9 * D + D / 2) begin
        mon_busy <= 1'b0;
        if (tx_out !== 1'b1) n_stop_err <= n_stop_err + 1;
        got_bytes.push_back(mon_sh);
      end else if (mon_cnt >= D + D / 2 && (mon_cnt % D) == D / 2) begin
        mon_sh <= {tx_out, mon_sh[7:1]};
      end
    end
  end

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    @(negedge clk);
    rx = 1'b0;
    repeat (D) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (D) @(negedge clk);
    end
    rx = stop;
    repeat (D) @(negedge clk);
    rx = 1'b1;
    repeat (2 * D) @(negedge clk);
  endtask

  task automatic wait_close(input int base);
    int k;
    k = 0;
    while (n_close == base && k < 4000) begin
      settle();
      k++;
    end
    check("dump_completed", 32'(n_close > base), 32'd1);
  endtask

  function automatic logic [7:0] exp_byte(input logic [W-1:0] d, input int i);
    if (i < NB) return d[W-1-8*i -: 8];
    if (i == NB) return 8'h0D;
    return 8'h0A;
  endfunction

  task automatic check_dump(input logic [W-1:0] d, input int b_base, input int p_base);
    check("byte_count", 32'(got_bytes.size() - b_base), 32'(NB_EXP));
    for (int i = 0; i < NB_EXP; i++) begin
      if (b_base + i < got_bytes.size())
        check($sformatf("byte%0d", i), 32'(got_bytes[b_base+i]), 32'(exp_byte(d, i)));
      if (p_base + i < pos_log.size())
        check($sformatf("pos%0d", i), 32'(pos_log[p_base+i]), 32'(i));
    end
    check("busy_after_dump", 32'(debug_command_busy), 32'd0);
    check("state_after_dump", 32'(currentState), 32'd0);
  endtask

  typedef struct {
    logic [7:0]   rx_byte;
    logic         stop;
    logic [W-1:0] data;
    int           exp_pulses;
    logic [7:0]   exp_cmd;
    int           exp_dumps;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, s0, c0, b0, l0, t0, k;

    vecs[0] = '{8'h33, 1'b1, 24'h000000, 1, 8'h33, 0};
    vecs[1] = '{8'h4C, 1'b1, 24'hF0AA0D, 1, 8'h4C, 1};
    vecs[2] = '{8'h5A, 1'b0, 24'h000000, 0, 8'h4C, 0};
    vecs[3] = '{8'h52, 1'b1, 24'h000000, 1, 8'h52, 0};
    vecs[4] = '{8'h4C, 1'b1, 24'h0155FE, 1, 8'h4C, 1};

    // Reset and idle state.
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (100) @(negedge clk);
    settle();
    check("rst_tx_out", 32'(tx_out), 32'd1);
    check("rst_state", 32'(currentState), 32'd0);
    check("rst_position", 32'(current_position), 32'd0);
    check("rst_command", 32'(debug_command), 32'd0);
    check("rst_strobes", 32'({debug_start, tx_start, debug_command_pulse, do_close,
                              debug_command_busy}), 32'd0);
    check("rst_no_events", 32'(n_pulse + n_start + n_close + n_txs), 32'd0);

    // Table-driven command vectors.
    for (int v = 0; v < 5; v++) begin
      settle();
      data_in = vecs[v].data;
      p0 = n_pulse; s0 = n_start; c0 = n_close;
      b0 = got_bytes.size(); l0 = pos_log.size();
      send_frame(vecs[v].rx_byte, vecs[v].stop);
      if (vecs[v].exp_dumps != 0) wait_close(c0);
      repeat (5) settle();
      check($sformatf("v%0d_pulses", v), 32'(n_pulse - p0), 32'(vecs[v].exp_pulses));
      check($sformatf("v%0d_command", v), 32'(debug_command), 32'(vecs[v].exp_cmd));
      check($sformatf("v%0d_starts", v), 32'(n_start - s0), 32'(vecs[v].exp_dumps));
      check($sformatf("v%0d_closes", v), 32'(n_close - c0), 32'(vecs[v].exp_dumps));
      if (vecs[v].exp_dumps != 0) check_dump(vecs[v].data, b0, l0);
      else check($sformatf("v%0d_no_bytes", v), 32'(got_bytes.size() - b0), 32'd0);
    end

    // Second 'L' arriving mid-dump is received but ignored by the sequencer.
    settle();
    data_in = 24'hF0AA0D;
    p0 = n_pulse; s0 = n_start; c0 = n_close;
    b0 = got_bytes.size(); l0 = pos_log.size();
    send_frame(8'h4C, 1'b1);
    check("busy_during_dump", 32'(debug_command_busy), 32'd1);
    data_in = 24'h111111;
    send_frame(8'h4C, 1'b1);
    wait_close(c0);
    repeat (100) settle();
    check("busy_l_pulses", 32'(n_pulse - p0), 32'd2);
    check("busy_l_starts", 32'(n_start - s0), 32'd1);
    check("busy_l_closes", 32'(n_close - c0), 32'd1);
    check_dump(24'hF0AA0D, b0, l0);

    // A fresh 'L' after close dumps again.
    s0 = n_start; c0 = n_close;
    b0 = got_bytes.size(); l0 = pos_log.size();
    send_frame(8'h4C, 1'b1);
    wait_close(c0);
    repeat (5) settle();
    check("redump_starts", 32'(n_start - s0), 32'd1);
    check_dump(24'h111111, b0, l0);

    // Reset in the middle of a transmitted byte.
    data_in = 24'h5A5AC3;
    t0 = n_txs;
    send_frame(8'h4C, 1'b1);
    k = 0;
    while (n_txs == t0 && k < 1000) begin
      settle();
      k++;
    end
    check("mid_reset_tx_began", 32'(n_txs > t0), 32'd1);
    repeat (3 * D) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("mid_reset_tx_out", 32'(tx_out), 32'd1);
    check("mid_reset_state", 32'(currentState), 32'd0);
    check("mid_reset_busy", 32'(debug_command_busy), 32'd0);
    check("mid_reset_command", 32'(debug_command), 32'd0);
    reset = 1'b0;
    repeat (20 * D) @(negedge clk);
    settle();
    s0 = n_start; c0 = n_close;
    b0 = got_bytes.size(); l0 = pos_log.size();
    data_in = 24'h9C3E81;
    send_frame(8'h4C, 1'b1);
    wait_close(c0);
    repeat (5) settle();
    check("post_reset_starts", 32'(n_start - s0), 32'd1);
    check_dump(24'h9C3E81, b0, l0);

    check("tx_stop_bits", 32'(n_stop_err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_debugger.md
Name: uart_debugger

Overview:
- UART debug port. Receives 8N1 command bytes on a serial input and, on a dump command, snapshots a parallel data word.
- Transmits the snapshot MSB-byte-first over a serial output.
- Sits beside the main datapath as a low-rate observation/control channel.
- Exposes its internal state (FSM, byte position, last command) for probing.

Parameters:
- DIVIDER_TICKS, 1023: clock cycles per UART bit, RX and TX. Legal range is at least 4.
- DATA_WIDTH, 24: width of data_in. Must be a multiple of 8, with DATA_WIDTH/8 ≤ 31.

Ports:
- clk_in  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- data_in  in  DATA_WIDTH  word to dump.
- debug_uart_rx_in  in  1  serial command input; idle high.
- tx_out  out  1  serial dump output; idle high.
- debug_start  out  1  one-cycle pulse when a dump begins.
- currentState  out  5  FSM state encoding.
- tx_start  out  1  one-cycle pulse launching one TX byte.
- current_position  out  5  index of the byte being sent.
- debug_command  out  8  last valid received byte.
- debug_command_pulse  out  1  one-cycle strobe when debug_command updates.
- debug_command_busy  out  1  high while a dump is in progress.
- do_close  out  1  one-cycle pulse when a dump completes.

Behaviour:
- Reset values: tx_out=1; currentState=IDLE(0); current_position=0; debug_command=0x00; all pulses and busy = 0.
- Reset mid-frame or mid-dump aborts immediately. tx_out goes high on the next cycle.
- RX framing:
  - A high→low transition while idle starts a frame.
  - The start bit is re-sampled at DIVIDER_TICKS/2. If it reads high, the frame is dropped.
  - 8 data bits, LSB first, are each sampled one DIVIDER_TICKS after the previous sample.
  - The stop bit must read 1. Otherwise the byte is discarded (framing error) and RX returns to idle.
  - The input is synchronised through 2 flops before use.
- Valid byte handling:
  - debug_command is updated and debug_command_pulse fires in the cycle after the stop-bit sample.
  - This applies to every valid byte, including bytes received while busy.
- FSM states: IDLE=0, LATCH=1, SEND=2, WAIT=3, ADVANCE=4, CLOSE=5.
  - IDLE: if debug_command_pulse && debug_command==CMD_DUMP (0x4C, 'L'), go to LATCH.
  - LATCH: snapshot data_in; current_position=0; debug_start=1; busy=1; go to SEND.
  - SEND: tx_start=1 loading the snapshot byte at current_position, where position 0 is bits [DATA_WIDTH-1 -: 8]; go to WAIT.
  - WAIT: stay until the TX stop bit has finished; go to ADVANCE.
  - ADVANCE: if current_position == DATA_WIDTH/8-1, go to CLOSE. Otherwise increment and go to SEND.
  - CLOSE: do_close=1; busy=0; current_position=0; go to IDLE.
- A dump command received while not in IDLE is ignored (no queueing).
- data_in changes after LATCH do not affect the dump in progress.
- TX frame: start bit 0, 8 data bits LSB first, stop bit 1, each exactly DIVIDER_TICKS cycles. tx_out stays high between bytes for at least one cycle.
- Encodings outside 0–5 recover to IDLE on the next cycle.
- Latency: debug_start fires 1 cycle after the triggering debug_command_pulse. The TX start bit begins 2 cycles after debug_start.

Optional Feature:
- Macro UART_DEBUGGER_CRLF_EN.
- Defined: after the DATA_WIDTH/8 data bytes, two more bytes 0x0D then 0x0A are sent via the same SEND/WAIT path. current_position continues counting to DATA_WIDTH/8+1 before CLOSE.
- Undefined: only the data bytes are sent.

Decomposition:
- Shared package uart_debugger_pkg holds:
  - the state enum (5-bit logic, values above);
  - CMD_DUMP = 8'h4C;
  - the CR/LF constants.
- One natural sub-module: debug_uart_tx (byte-in, start pulse, busy/done out, bit-period counter).
- RX and the FSM stay in the top module.

Test Plan (DIVIDER_TICKS=16 for speed):
- Reset held 3 cycles, then idle 100 cycles → tx_out=1, currentState=0, all strobes 0, debug_command=0x00.
- RX byte 0x33 → debug_command=0x33, one debug_command_pulse, no debug_start, FSM stays IDLE.
- data_in=24'hF0AA0D, RX 'L' → debug_start pulse, busy high. tx_out frames decode to F0, AA, 0D in order. current_position steps 0,1,2. One do_close pulse, then busy low.
- Second 'L' sent during a dump → debug_command_pulse fires, but no second dump starts and the byte count stays 3. A later 'L' sent after do_close starts a new dump.
- RX frame with stop bit 0 → no pulse, debug_command unchanged. A following valid 0x52 is received correctly.
- Reset asserted mid-byte of a dump → next cycle tx_out=1, currentState=0, busy=0. A subsequent 'L' dumps normally.
- With UART_DEBUGGER_CRLF_EN defined → the output sequence is F0, AA, 0D, 0D, 0A.
